uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo_if.sv | 27 ++
 rtl/uart_tx_fifo.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Producer-side handshake bundle for uart_tx_fifo.
// The producer (master) offers bytes with tx_valid/tx_data. The transmitter
// (slave) answers with tx_ready and reports how many bytes are queued.
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [CNT_W-1:0] fifo_count;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  fifo_count
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output fifo_count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a byte FIFO fed by a valid/ready handshake,
// drained back-to-back by a serializer at CLK_HZ/BAUD (rounded).
// Default frame is 8N1. Defining UART_TX_PARITY_EN inserts an even-parity
// bit after the data bits, which makes the frame 8E1.
// txd is registered and idles high. Reset is asynchronous and active-low.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          CLOCK,
  input  logic          RESET_N,
  uart_tx_fifo_if.slave bus,
  output logic          tx_busy,
  output logic          txd
);

  // Clock cycles per line bit, rounded to the nearest integer.
  localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;
  logic [7:0]       head;

  // Ready depends only on the registered count, so tx_valid has no
  // combinational path to tx_ready.
  assign bus.tx_ready   = (count < DEPTH_C);
  assign bus.fifo_count = count;
  assign push           = bus.tx_valid && bus.tx_ready;
  assign head           = mem[rd_ptr];

  // Store the accepted byte at the write pointer.
  // NOTE: the storage array has no reset. Its contents are don't-care until
  // they are written, and leaving out the reset lets the array map onto RAM.
  always_ff @(posedge CLOCK) begin
    if (push) begin
      mem[wr_ptr] <= bus.tx_data;
    end
  end

  // Pointers wrap naturally. Count tracks push and pop, and a simultaneous
  // push and pop leaves it unchanged.
  // NOTE: sequential state uses non-blocking assignments only. Every
  // register then updates from the values before the edge, whatever the
  // block order.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Serializer
  // ---------------------------------------------------------------------
  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] baud_cnt;
  logic [CNT_W-1:0] baud_cnt_n;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_n;
  logic [7:0]       shift;
  logic [7:0]       shift_n;
  logic             txd_q;
  logic             txd_n;
  logic             baud_end;
  logic             fifo_nonempty;
  logic             load;
`ifdef UART_TX_PARITY_EN
  logic             parity_q;
  logic             parity_n;
`endif

  assign baud_end      = (baud_cnt == BAUD_LAST);
  assign fifo_nonempty = (count != '0);

  // Next-state logic, including the FIFO pop and the level txd takes after
  // the edge. Because txd is computed from the next state, it changes on the
  // same edge as the state does.
  // NOTE: every variable gets a default at the top of the block. Without
  // that, a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    load       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_n   = parity_q;
`endif

    case (state)
      S_IDLE: begin
        load = fifo_nonempty;
      end

      S_START: begin
        if (baud_end) begin
          baud_cnt_n = '0;
          state_n    = S_DATA;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_end) begin
          baud_cnt_n = '0;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            shift_n   = {1'b0, shift[7:1]};
            bit_idx_n = bit_idx + 1'b1;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          baud_cnt_n = '0;
          state_n    = S_STOP;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (baud_end) begin
          baud_cnt_n = '0;
          state_n    = S_IDLE;
          // A queued byte starts its frame with no idle gap.
          load       = fifo_nonempty;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Pop the head into the shift register and begin a new frame.
    if (load) begin
      shift_n    = head;
      baud_cnt_n = '0;
      bit_idx_n  = '0;
      state_n    = S_START;
`ifdef UART_TX_PARITY_EN
      parity_n   = ^head;
`endif
    end

    txd_n = 1'b1;
    case (state_n)
      S_START:  txd_n = 1'b0;
      S_DATA:   txd_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_n = parity_n;
`endif
      default:  txd_n = 1'b1;
    endcase
  end

  assign pop = load;

  // Serializer state register. Reset forces the line high and drops any
  // frame that is in flight.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      txd_q    <= txd_n;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_n;
`endif
    end
  end

  assign txd     = txd_q;
  assign tx_busy = (state != S_IDLE) || fifo_nonempty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with CLK_HZ=1 MHz and BAUD=100 kHz,
// which gives 10 cycles per bit. Define UART_TX_PARITY_EN for the 8E1 build.
// Line levels are predicted from the frame format, and a line receiver
// decodes txd into a byte scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int DEPTH  = 16;
  localparam int DIV    = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME = FB * DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tx_busy;
  logic txd;

  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .bus     (bus.slave),
    .tx_busy (tx_busy),
    .txd     (txd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic       mon_en = 1'b1;

  typedef struct {
    logic [7:0] data;
    logic       exp_par;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Line level in bit slot pos of a frame that carries byte b.
  function automatic logic line_level(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos - 1];
    if (FB == 11 && pos == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (tx_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(tx_busy), 32'd0);
  endtask

  // Push one byte into an idle DUT. Returns at the negedge that follows the
  // handshake edge.
  task automatic push_one(input logic [7:0] b);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  // Push three bytes on consecutive edges and record fifo_count at each of
  // the three following negedges.
  task automatic burst3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        output int c0, output int c1, output int c2, output logic t1);
    bus.tx_data = a; bus.tx_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    c0 = int'(bus.fifo_count);
    bus.tx_data = b;
    @(posedge clk); @(negedge clk);
    c1 = int'(bus.fifo_count);
    t1 = txd;
    bus.tx_data = c;
    @(posedge clk); @(negedge clk);
    bus.tx_valid = 1'b0;
    c2 = int'(bus.fifo_count);
  endtask

  // Line receiver: finds the start bit, then samples the middle of every bit.
  initial begin : monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && txd == 1'b0) begin
        repeat (DIV / 2 - 1) @(negedge clk);
        if (mon_en) check("rx_start", 32'(txd), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = txd;
        end
        if (FB == 11) begin
          repeat (DIV) @(negedge clk);
          if (mon_en) check("rx_parity", 32'(txd), 32'(^b));
        end
        repeat (DIV) @(negedge clk);
        if (mon_en) begin
          check("rx_stop", 32'(txd), 32'd1);
          rx_q.push_back(b);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  initial begin : stim
    int c0, c1, c2;
    logic t1;
    logic [7:0] b3 [3];
    logic [7:0] d;
    logic exp;
    int acc, cyc, w;
    logic saw_full;

    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b0};
    vecs[3] = '{8'h07, 1'b1};
    vecs[4] = '{8'h03, 1'b0};
    vecs[5] = '{8'h80, 1'b1};
    vecs[6] = '{8'h3C, 1'b0};
    vecs[7] = '{8'h5A, 1'b0};

    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;

    // Reset idle.
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_count", 32'(bus.fifo_count), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_txd", 32'(txd), 32'd1);
      check("idle_ready", 32'(bus.tx_ready), 32'd1);
      check("idle_busy", 32'(tx_busy), 32'd0);
      check("idle_count", 32'(bus.fifo_count), 32'd0);
    end

    // Table-driven single frames, checked every cycle.
    foreach (vecs[v]) begin
      check("tbl_ready", 32'(bus.tx_ready), 32'd1);
      push_one(vecs[v].data);
      check("tbl_latency_txd", 32'(txd), 32'd1);
      check("tbl_count1", 32'(bus.fifo_count), 32'd1);
      for (int k = 0; k < FRAME; k++) begin
        @(negedge clk);
        exp = (FB == 11 && k / DIV == 9) ? vecs[v].exp_par : line_level(vecs[v].data, k / DIV);
        check("tbl_txd", 32'(txd), 32'(exp));
        if (k == 0) check("tbl_count0", 32'(bus.fifo_count), 32'd0);
      end
      @(negedge clk);
      check("tbl_busy_end", 32'(tx_busy), 32'd0);
      check("tbl_txd_end", 32'(txd), 32'd1);
      repeat (3) @(negedge clk);
    end

    // Back-to-back: three contiguous frames with no idle gap.
    b3[0] = 8'h00; b3[1] = 8'hFF; b3[2] = 8'h55;
    burst3(b3[0], b3[1], b3[2], c0, c1, c2, t1);
    check("b2b_count_a", 32'(c0), 32'd1);
    check("b2b_count_b", 32'(c1), 32'd1);
    check("b2b_txd_k0", 32'(t1), 32'd0);
    check("b2b_count_c", 32'(c2), 32'd2);
    check("b2b_txd_k1", 32'(txd), 32'(line_level(b3[0], 0)));
    for (int k = 2; k < 3 * FRAME; k++) begin
      @(negedge clk);
      check("b2b_txd", 32'(txd), 32'(line_level(b3[k / FRAME], (k % FRAME) / DIV)));
      if (k == FRAME - 1)     check("b2b_count_2", 32'(bus.fifo_count), 32'd2);
      if (k == FRAME)         check("b2b_count_1", 32'(bus.fifo_count), 32'd1);
      if (k == 2 * FRAME - 1) check("b2b_count_1b", 32'(bus.fifo_count), 32'd1);
      if (k == 2 * FRAME)     check("b2b_count_0", 32'(bus.fifo_count), 32'd0);
    end
    @(negedge clk);
    check("b2b_busy_end", 32'(tx_busy), 32'd0);

    // Reset mid-frame: 35 cycles into the 0x3C frame, 2 bytes queued.
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    burst3(8'h3C, 8'h11, 8'h22, c0, c1, c2, t1);
    check("rmf_queued", 32'(c2), 32'd2);
    repeat (34) @(negedge clk);
    check("rmf_txd_pre", 32'(txd), 32'(line_level(8'h3C, 3)));
    #1 rst_n = 1'b0;
    #1;
    check("rmf_txd_async", 32'(txd), 32'd1);
    check("rmf_count_async", 32'(bus.fifo_count), 32'd0);
    check("rmf_ready_async", 32'(bus.tx_ready), 32'd1);
    check("rmf_busy_async", 32'(tx_busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      check("rmf_quiet_txd", 32'(txd), 32'd1);
      check("rmf_quiet_busy", 32'(tx_busy), 32'd0);
    end
    mon_en = 1'b1;

    // Full FIFO and backpressure: tx_valid held high, data advances on accept.
    rx_q.delete(); exp_q.delete();
    acc = 0; cyc = 0; saw_full = 1'b0;
    bus.tx_data = 8'h00; bus.tx_valid = 1'b1;
    while (acc < 24 && cyc < 40 * FRAME) begin
      check("bp_ready_rule", 32'(bus.tx_ready), 32'(int'(bus.fifo_count) < DEPTH));
      if (int'(bus.fifo_count) == DEPTH) saw_full = 1'b1;
      if (bus.tx_ready) begin
        exp_q.push_back(bus.tx_data);
        acc++;
      end
      @(posedge clk); @(negedge clk);
      if (exp_q.size() == acc && acc > 0 && bus.tx_data == exp_q[acc - 1]) bus.tx_data = bus.tx_data + 8'd1;
      cyc++;
    end
    bus.tx_valid = 1'b0;
    check("bp_accepts", 32'(acc), 32'd24);
    check("bp_saw_full", 32'(saw_full), 32'd1);
    wait_idle("bp_drain", 30 * FRAME);
    check("bp_len", 32'(rx_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < rx_q.size()) check("bp_byte", 32'(rx_q[i]), 32'(exp_q[i]));
    end

    // Randomized traffic against the byte scoreboard.
    repeat (5) @(negedge clk);
    rx_q.delete(); exp_q.delete();
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, (n % 5 == 0) ? 150 : 3)) @(negedge clk);
      d = 8'($urandom);
      bus.tx_data = d; bus.tx_valid = 1'b1;
      w = 0;
      while (!bus.tx_ready && w < 2000) begin
        @(negedge clk);
        w++;
      end
      if (w >= 2000) check("rnd_ready_timeout", 32'(bus.tx_ready), 32'd1);
      exp_q.push_back(d);
      @(posedge clk); @(negedge clk);
      bus.tx_valid = 1'b0;
    end
    wait_idle("rnd_drain", 40 * FRAME);
    check("rnd_len", 32'(rx_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < rx_q.size()) check("rnd_byte", 32'(rx_q[i]), 32'(exp_q[i]));
    end
    check("rnd_txd_idle", 32'(txd), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
